// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: turns one CPU load/store into word-wide memory traffic,
// with lane extraction for loads and read-modify-write for sub-word stores.
module lsu_mem_ctrl #(
    parameter int unsigned MEM_WORDS = 131072
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {StIdle, StRead, StWait, StWrite, StDone} state_t;

    localparam logic [31:0] WordMask = 32'(MEM_WORDS - 1);

    state_t      state_q, state_d;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;

    logic        accept;
    logic        req_err;
    logic [31:0] word_idx;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_data;
    logic [31:0] merge_mask;
    logic [31:0] merge_ins;
    logic [31:0] merge_data;

    logic [31:0] mem_addr_d, mem_wdata_d, rsp_rdata_d;
    logic        mem_we_d, rsp_valid_d, rsp_err_d;

    // Gated by rst so the CPU never sees ready while the block is held in reset.
    assign req_ready = (state_q == StIdle) && !rst;
    assign accept    = req_valid && req_ready;
    assign word_idx  = {2'b00, req_addr[31:2]} & WordMask;

    always_comb begin
        req_err = 1'b1;
        if (!req_we) begin
            case (req_funct3)
                3'd0, 3'd4: req_err = 1'b0;
                3'd1, 3'd5: req_err = req_addr[0];
                3'd2:       req_err = |req_addr[1:0];
                default:    req_err = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                3'd0:    req_err = 1'b0;
                3'd1:    req_err = req_addr[0];
                3'd2:    req_err = |req_addr[1:0];
                default: req_err = 1'b1;
            endcase
        end
    end

    // Load lane extraction (little-endian lanes).
    always_comb begin
        byte_v = 8'(mem_rdata >> {off_q, 3'b000});
        half_v = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'd0:    load_data = {{24{byte_v[7]}}, byte_v};
            3'd1:    load_data = {{16{half_v[15]}}, half_v};
            3'd4:    load_data = {24'b0, byte_v};
            3'd5:    load_data = {16'b0, half_v};
            default: load_data = mem_rdata;
        endcase
    end

    // Sub-word store merge: funct3[0]=0 is SB, 1 is SH.
    always_comb begin
        if (!funct3_q[0]) begin
            merge_mask = 32'h0000_00ff << {off_q, 3'b000};
            merge_ins  = {24'b0, wdata_q[7:0]} << {off_q, 3'b000};
        end else begin
            merge_mask = 32'h0000_ffff << {off_q[1], 4'b0000};
            merge_ins  = {16'b0, wdata_q} << {off_q[1], 4'b0000};
        end
        merge_data = (mem_rdata & ~merge_mask) | merge_ins;
    end

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (req_err) begin
                        state_d     = StDone;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'b0;
                    end else begin
                        mem_addr_d = word_idx;
                        if (req_we && req_funct3 == 3'd2) begin
                            state_d     = StWrite;
                            mem_we_d    = 1'b1;
                            mem_wdata_d = req_wdata;
                        end else begin
                            state_d = StRead;
                        end
                    end
                end
            end
            StRead: state_d = StWait;
            StWait: begin
                if (we_q) begin
                    state_d     = StWrite;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = merge_data;
                end else begin
                    state_d     = StDone;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_data;
                    rsp_err_d   = 1'b0;
                end
            end
            StWrite: begin
                state_d     = StDone;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = 32'b0;
                rsp_err_d   = 1'b0;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            mem_addr  <= 32'b0;
            mem_we    <= 1'b0;
            mem_wdata <= 32'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'b0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_addr  <= mem_addr_d;
            mem_we    <= mem_we_d;
            mem_wdata <= mem_wdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b0;
            off_q    <= 2'b0;
            wdata_q  <= 16'b0;
        end else if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            off_q    <= req_addr[1:0];
            wdata_q  <= req_wdata[15:0];
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a registered-read word memory model.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    lsu_mem_ctrl #(.MEM_WORDS(131072)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:131071];
    int          wr_cnt = 0;
    logic [31:0] last_wa, last_wd;

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[16:0]] <= mem_wdata;
            wr_cnt  <= wr_cnt + 1;
            last_wa <= mem_addr;
            last_wd <= mem_wdata;
        end else begin
            mem_rdata <= mem[mem_addr[16:0]];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request; lat = negedges after the accept edge until rsp_valid (0 = none).
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output int lat);
        @(negedge clk);
        check("ready_before_req", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (rsp_valid) lat = k;
        end
    endtask

    int lat, w0;
    logic [31:0] exp_ready [1:7];
    logic [31:0] exp_rsp   [1:7];
    int pulses;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'b0; req_wdata = 32'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", {31'b0, rsp_err}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        // 1: SW then LW
        w0 = wr_cnt;
        run_req(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, lat);
        check("sw_lat", lat, 32'd2);
        check("sw_writes", wr_cnt - w0, 32'd1);
        check("sw_waddr", last_wa, 32'd4);
        check("sw_wdata", last_wd, 32'hDEAD_BEEF);
        check("sw_err", {31'b0, rsp_err}, 32'd0);
        run_req(1'b0, 3'd2, 32'h10, 32'h0, lat);
        check("lw_lat", lat, 32'd3);
        check("lw_data", rsp_rdata, 32'hDEAD_BEEF);
        check("lw_err", {31'b0, rsp_err}, 32'd0);
        @(negedge clk);
        check("lw_single_pulse", {31'b0, rsp_valid}, 32'd0);
        check("lw_data_hold", rsp_rdata, 32'hDEAD_BEEF);

        // 2: sub-word loads
        run_req(1'b1, 3'd2, 32'h10, 32'h8077_F0A5, lat);
        run_req(1'b0, 3'd0, 32'h10, 32'h0, lat);
        check("lb_10", rsp_rdata, 32'hFFFF_FFA5);
        run_req(1'b0, 3'd4, 32'h11, 32'h0, lat);
        check("lbu_11", rsp_rdata, 32'h0000_00F0);
        run_req(1'b0, 3'd1, 32'h12, 32'h0, lat);
        check("lh_12", rsp_rdata, 32'hFFFF_8077);
        run_req(1'b0, 3'd5, 32'h12, 32'h0, lat);
        check("lhu_12", rsp_rdata, 32'h0000_8077);
        check("lhu_lat", lat, 32'd3);
        run_req(1'b0, 3'd0, 32'h13, 32'h0, lat);
        check("lb_13", rsp_rdata, 32'hFFFF_FF80);
        run_req(1'b0, 3'd1, 32'h10, 32'h0, lat);
        check("lh_10", rsp_rdata, 32'hFFFF_F0A5);

        // 3: read-modify-write stores
        run_req(1'b1, 3'd2, 32'h20, 32'h1122_3344, lat);
        w0 = wr_cnt;
        run_req(1'b1, 3'd0, 32'h21, 32'h0000_00AB, lat);
        check("sb_lat", lat, 32'd4);
        check("sb_writes", wr_cnt - w0, 32'd1);
        check("sb_wdata", last_wd, 32'h1122_AB44);
        check("sb_waddr", last_wa, 32'd8);
        check("sb_rdata", rsp_rdata, 32'd0);
        run_req(1'b1, 3'd1, 32'h22, 32'h0000_CAFE, lat);
        check("sh_wdata", last_wd, 32'hCAFE_AB44);
        run_req(1'b0, 3'd2, 32'h20, 32'h0, lat);
        check("lw_after_rmw", rsp_rdata, 32'hCAFE_AB44);

        // 4: errors
        w0 = wr_cnt;
        run_req(1'b0, 3'd2, 32'h13, 32'h0, lat);
        check("lw_mis_lat", lat, 32'd1);
        check("lw_mis_err", {31'b0, rsp_err}, 32'd1);
        check("lw_mis_rdata", rsp_rdata, 32'd0);
        run_req(1'b1, 3'd1, 32'h21, 32'h0000_1234, lat);
        check("sh_mis_err", {31'b0, rsp_err}, 32'd1);
        run_req(1'b0, 3'd7, 32'h20, 32'h0, lat);
        check("ld_f7_err", {31'b0, rsp_err}, 32'd1);
        run_req(1'b1, 3'd3, 32'h20, 32'hFFFF_FFFF, lat);
        check("st_f3_err", {31'b0, rsp_err}, 32'd1);
        check("err_no_writes", wr_cnt - w0, 32'd0);
        run_req(1'b0, 3'd2, 32'h20, 32'h0, lat);
        check("err_mem_unchanged", rsp_rdata, 32'hCAFE_AB44);
        check("err_cleared", {31'b0, rsp_err}, 32'd0);

        // 5: back-to-back with req_valid held high
        exp_ready = '{32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1};
        exp_rsp   = '{32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0};
        pulses = 0;
        @(negedge clk);
        check("b2b_ready0", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h30; req_wdata = 32'h5555_AAAA;
        @(posedge clk);
        #1 req_we = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check($sformatf("b2b_ready_%0d", k), {31'b0, req_ready}, exp_ready[k]);
            check($sformatf("b2b_rsp_%0d", k), {31'b0, rsp_valid}, exp_rsp[k]);
            if (rsp_valid) pulses++;
            if (k == 6) check("b2b_lw_data", rsp_rdata, 32'h5555_AAAA);
        end
        req_valid = 1'b0;
        check("b2b_pulses", pulses, 32'd2);

        // 6: reset during WAIT of an SB, then address wrap
        @(negedge clk);
        w0 = wr_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0;
        req_addr = 32'h21; req_wdata = 32'h0000_0077;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_mem_we", {31'b0, mem_we}, 32'd0);
        check("abort_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        check("abort_no_rsp", pulses, 32'd0);
        check("abort_no_write", wr_cnt - w0, 32'd0);
        run_req(1'b0, 3'd2, 32'h20, 32'h0, lat);
        check("abort_word", rsp_rdata, 32'hCAFE_AB44);
        run_req(1'b1, 3'd2, 32'h4, 32'h1357_2468, lat);
        run_req(1'b0, 3'd2, 32'h0008_0004, 32'h0, lat);
        check("wrap_mem_addr", mem_addr, 32'h0000_0001);
        check("wrap_data", rsp_rdata, 32'h1357_2468);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store initiator between the CPU execute stage and the word-organised data memory. Accepts one RISC-V load or store per handshake (LB/LH/LW/LBU/LHU/SB/SH/SW) and converts byte addresses to word indices. Performs byte-lane extraction with sign/zero extension for loads, and read-modify-write for sub-word stores. The data memory writes whole words only, and its read data is registered, arriving one cycle after the address.

Parameters:
MEM_WORDS, 131072, depth of data memory in words; word index wraps modulo MEM_WORDS (power of two).

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  CPU request present
req_ready  out  1  block can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3 of the load/store
req_addr  in  32  byte address
req_wdata  in  32  store data (low bytes used for SB/SH)
rsp_valid  out  1  one-cycle pulse: request complete
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  with rsp_valid: misaligned or illegal funct3
mem_addr  out  32  word index = req_addr[31:2] mod MEM_WORDS, zero-extended
mem_we  out  1  memory write enable
mem_wdata  out  32  memory write data
mem_rdata  in  32  registered memory read data, valid the cycle after mem_addr with mem_we=0

Behaviour:
- Reset values: req_ready=0 while rst is high, then 1 in IDLE. rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_addr=0, mem_we=0, mem_wdata=0. State is IDLE.
- All outputs are registered; req_ready is decoded from state.
- Handshake: a request is accepted on a rising edge with req_valid && req_ready. All request fields are latched at that edge. No queuing, and the CPU sees no backpressure on the response.
- States: IDLE, READ, WAIT, WRITE, DONE.
- Error check at accept:
  - Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
  - Illegal funct3: loads 3/6/7; stores 3–7.
  - On error: IDLE->DONE, no memory access, rsp_err=1, rsp_rdata=0.
- SW: IDLE->WRITE->DONE->IDLE.
  - In WRITE, mem_we=1 and mem_wdata=req_wdata.
  - rsp_valid appears 2 cycles after accept.
- Loads: IDLE->READ->WAIT->DONE->IDLE.
  - In READ, mem_we=0 and mem_addr is driven.
  - In WAIT, mem_rdata is sampled and extracted:
    - Byte lane = addr[1:0] (little-endian).
    - Halfword lane = addr[1].
    - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - rsp_valid appears 3 cycles after accept.
- SB/SH: IDLE->READ->WAIT->WRITE->DONE->IDLE.
  - In WAIT, req_wdata[7:0] or [15:0] is merged into the addressed lane of mem_rdata; other lanes are preserved.
  - In WRITE, mem_we=1 with the merged word.
  - rsp_valid appears 4 cycles after accept.
- DONE: rsp_valid=1 for exactly one cycle. rsp_rdata/rsp_err hold their values until the next DONE.
- Idle outputs: mem_we=1 only in WRITE. mem_addr holds the last value outside READ/WAIT/WRITE.
- req_valid while busy is ignored (req_ready=0). A new request may be accepted in the cycle after DONE.
- rst asserted mid-operation: immediate return to IDLE with mem_we=0.
  - A pending RMW write is aborted; memory is unchanged, because the merge write never issued.
  - No rsp_valid is produced for the aborted request.
- Address wrap: mem_addr = (req_addr>>2) & (MEM_WORDS-1).

Test Plan:
1. SW addr 0x10, data 0xDEADBEEF, then LW 0x10 -> mem_we high in one cycle with mem_addr=4; LW rsp_valid 3 cycles after accept; rsp_rdata=0xDEADBEEF, rsp_err=0.
2. Word at 0x10 = 0x8077_F0A5:
   - LB 0x10 -> 0xFFFFFFA5.
   - LBU 0x11 -> 0x000000F0.
   - LH 0x12 -> 0xFFFF8077.
   - LHU 0x12 -> 0x00008077.
3. Word 0x11223344 at 0x20:
   - SB 0x21 data 0xAB -> one write of 0x1122AB44; rsp 4 cycles after accept.
   - SH 0x22 data 0xCAFE -> 0xCAFEAB44.
4. Errors, each with no mem_we pulse and memory unchanged:
   - LW 0x13 -> rsp_valid 1 cycle after accept, rsp_err=1, rsp_rdata=0.
   - SH 0x21 -> rsp_err=1.
   - Load funct3=7 -> rsp_err=1.
5. Hold req_valid high continuously with back-to-back SW/LW -> req_ready low from accept through DONE; second request accepted the cycle after DONE; each request produces exactly one rsp_valid.
6. Assert rst during WAIT of SB 0x21 -> mem_we stays 0, no rsp_valid, a following LW returns the original word; LW 0x0008_0004 with MEM_WORDS=131072 -> mem_addr=0x00000001.
